// File: rtl/frh_pkg.sv
// Shared encodings for the FRHealth interval sequencer.
// Phase codes double as the FSM state encoding.
package frh_pkg;

    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_WORK  = 2'b01;
    localparam logic [1:0] PH_REST  = 2'b10;
    localparam logic [1:0] PH_PAUSE = 2'b11;

    localparam logic [1:0] BU_OFF  = 2'b00;
    localparam logic [1:0] BU_ADV  = 2'b01;
    localparam logic [1:0] BU_SKIP = 2'b10;
    localparam logic [1:0] BU_DONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WORK  = 2'b01,
        S_REST  = 2'b10,
        S_PAUSE = 2'b11
    } state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable seconds down-counter; saturates at zero and freezes on hold.
module phase_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         re,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (en && !hold && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/interval_sequencer.sv
// Workout/rest interval sequencer with skip, pause/resume and done pulse.
// All outputs are registered; events take effect on the next posedge.
module interval_sequencer
    import frh_pkg::*;
#(
    parameter int CNT_W = 9,
    parameter int TI_W  = 6,
    parameter int N_EX  = 10,
    parameter int EX_W  = 4
) (
    input  logic             Clk,
    input  logic             Re,
    input  logic             Tick,
    input  logic             St,
    input  logic             Sk,
    input  logic             Pa,
    input  logic [CNT_W-1:0] Total,
    input  logic [TI_W-1:0]  WorkSec,
    input  logic [TI_W-1:0]  RestSec,
    output logic [CNT_W-1:0] Cn,
    output logic [TI_W-1:0]  Ti,
    output logic [EX_W-1:0]  WCn,
    output logic [1:0]       Phase,
    output logic [1:0]       Bu,
    output logic             Done
);

    state_e           state_q, state_d;
    logic             ret_q, ret_d;
    logic [CNT_W-1:0] cn_q, cn_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [EX_W-1:0]  wcn_q, wcn_d;
    logic [TI_W-1:0]  work_q, work_d;
    logic [TI_W-1:0]  rest_q, rest_d;
    logic [1:0]       bu_q, bu_d;
    logic             done_q, done_d;

    logic             ld, dec, fin, adv, zero;
    logic [TI_W-1:0]  ld_val;
    logic [1:0]       adv_code;

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cn_d     = cn_q;
        tot_d    = tot_q;
        wcn_d    = wcn_q;
        work_d   = work_q;
        rest_d   = rest_q;
        bu_d     = Tick ? BU_OFF : bu_q;
        done_d   = 1'b0;
        ld       = 1'b0;
        ld_val   = work_q;
        dec      = 1'b0;
        fin      = 1'b0;
        adv      = 1'b0;
        adv_code = BU_ADV;

        unique case (state_q)
            S_IDLE: begin
                if (St && Total != '0) begin
                    tot_d   = Total;
                    work_d  = WorkSec;
                    rest_d  = RestSec;
                    cn_d    = CNT_W'(1);
                    wcn_d   = '0;
                    ld      = 1'b1;
                    ld_val  = WorkSec;
                    state_d = S_WORK;
                end
            end
            S_WORK, S_REST: begin
                if (Pa) begin
                    ret_d   = (state_q == S_REST);
                    state_d = S_PAUSE;
                end else if (Sk) begin
                    if (cn_q == tot_q) begin
                        fin = 1'b1;
                    end else begin
                        adv      = 1'b1;
                        adv_code = BU_SKIP;
                    end
                end else if (Tick) begin
                    if (!zero) begin
                        dec = 1'b1;
                    end else if (state_q == S_WORK) begin
                        ld      = 1'b1;
                        ld_val  = rest_q;
                        state_d = S_REST;
                    end else if (cn_q == tot_q) begin
                        fin = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (Pa) begin
                    state_d = ret_q ? S_REST : S_WORK;
                end
            end
        endcase

        if (adv) begin
            cn_d    = cn_q + CNT_W'(1);
            wcn_d   = (wcn_q == EX_W'(N_EX - 1)) ? '0 : wcn_q + EX_W'(1);
            ld      = 1'b1;
            ld_val  = work_q;
            bu_d    = adv_code;
            state_d = S_WORK;
        end

        if (fin) begin
            bu_d    = BU_DONE;
            done_d  = 1'b1;
            ld      = 1'b1;
            ld_val  = '0;
            wcn_d   = '0;
            cn_d    = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Re) begin
            state_q <= S_IDLE;
            ret_q   <= 1'b0;
            cn_q    <= '0;
            tot_q   <= '0;
            wcn_q   <= '0;
            work_q  <= '0;
            rest_q  <= '0;
            bu_q    <= BU_OFF;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cn_q    <= cn_d;
            tot_q   <= tot_d;
            wcn_q   <= wcn_d;
            work_q  <= work_d;
            rest_q  <= rest_d;
            bu_q    <= bu_d;
            done_q  <= done_d;
        end
    end

    phase_timer #(
        .W(TI_W)
    ) u_timer (
        .clk  (Clk),
        .re   (Re),
        .load (ld),
        .value(ld_val),
        .en   (dec),
        .hold (state_q == S_PAUSE),
        .count(Ti),
        .zero (zero)
    );

    assign Cn    = cn_q;
    assign WCn   = wcn_q;
    assign Phase = state_q;
    assign Bu    = bu_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_interval_sequencer.sv
// Table-driven bench for interval_sequencer with an expected-value queue.
// Runs with N_EX=3 so the exercise-slot wrap is reachable.
module tb_interval_sequencer;

    localparam int CNT_W = 9;
    localparam int TI_W  = 6;
    localparam int N_EX  = 3;
    localparam int EX_W  = 4;

    typedef struct {
        logic             re, st, sk, pa, tk;
        logic [CNT_W-1:0] tot;
        logic [TI_W-1:0]  ws, rs;
        logic [CNT_W-1:0] cn;
        logic [TI_W-1:0]  ti;
        logic [EX_W-1:0]  wcn;
        logic [1:0]       ph, bu;
        logic             dn;
    } vec_t;

    logic             clk = 1'b0;
    logic             re, tick, st, sk, pa;
    logic [CNT_W-1:0] total;
    logic [TI_W-1:0]  work_sec, rest_sec;
    logic [CNT_W-1:0] cn;
    logic [TI_W-1:0]  ti;
    logic [EX_W-1:0]  wcn;
    logic [1:0]       phase, bu;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs[$];
    vec_t sb[$];
    logic [CNT_W-1:0] c_tot;
    logic [TI_W-1:0]  c_ws, c_rs;

    always #5 clk = ~clk;

    interval_sequencer #(
        .CNT_W(CNT_W), .TI_W(TI_W), .N_EX(N_EX), .EX_W(EX_W)
    ) dut (
        .Clk(clk), .Re(re), .Tick(tick), .St(st), .Sk(sk), .Pa(pa),
        .Total(total), .WorkSec(work_sec), .RestSec(rest_sec),
        .Cn(cn), .Ti(ti), .WCn(wcn), .Phase(phase), .Bu(bu), .Done(done)
    );

    task automatic cfg(input int t, input int w, input int r);
        c_tot = CNT_W'(t);
        c_ws  = TI_W'(w);
        c_rs  = TI_W'(r);
    endtask

    task automatic add(input logic r, input logic s, input logic k,
                       input logic p, input logic t, input int ecn,
                       input int eti, input int ew, input int eph,
                       input int ebu, input logic edn);
        vec_t v;
        v.re = r; v.st = s; v.sk = k; v.pa = p; v.tk = t;
        v.tot = c_tot; v.ws = c_ws; v.rs = c_rs;
        v.cn = CNT_W'(ecn); v.ti = TI_W'(eti); v.wcn = EX_W'(ew);
        v.ph = 2'(eph); v.bu = 2'(ebu); v.dn = edn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        re = v.re; st = v.st; sk = v.sk; pa = v.pa; tick = v.tk;
        total = v.tot; work_sec = v.ws; rest_sec = v.rs;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d.Cn", idx), int'(cn), int'(e.cn));
        chk($sformatf("v%0d.Ti", idx), int'(ti), int'(e.ti));
        chk($sformatf("v%0d.WCn", idx), int'(wcn), int'(e.wcn));
        chk($sformatf("v%0d.Phase", idx), int'(phase), int'(e.ph));
        chk($sformatf("v%0d.Bu", idx), int'(bu), int'(e.bu));
        chk($sformatf("v%0d.Done", idx), int'(done), int'(e.dn));
    endtask

    initial begin
        int ticks;
        bit seen;
        re = 1'b1; tick = 0; st = 0; sk = 0; pa = 0;
        total = '0; work_sec = '0; rest_sec = '0;

        // reset
        cfg(2, 3, 2);
        add(1,0,0,0,0, 0,0,0,0,0,0);
        // ticks-only run: Total=2 W=3 R=2
        add(0,1,0,0,0, 1,3,0,1,0,0);
        add(0,0,0,0,1, 1,2,0,1,0,0);
        add(0,0,0,0,1, 1,1,0,1,0,0);
        add(0,0,0,0,1, 1,0,0,1,0,0);
        add(0,0,0,0,1, 1,2,0,2,0,0);
        add(0,0,0,0,1, 1,1,0,2,0,0);
        add(0,0,0,0,1, 1,0,0,2,0,0);
        add(0,0,0,0,1, 2,3,1,1,1,0);
        add(0,0,0,0,1, 2,2,1,1,0,0);
        add(0,0,0,0,1, 2,1,1,1,0,0);
        add(0,0,0,0,1, 2,0,1,1,0,0);
        add(0,0,0,0,1, 2,2,1,2,0,0);
        add(0,0,0,0,1, 2,1,1,2,0,0);
        add(0,0,0,0,1, 2,0,1,2,0,0);
        add(0,0,0,0,1, 0,0,0,0,3,1);
        add(0,0,0,0,0, 0,0,0,0,3,0);
        add(0,0,0,0,1, 0,0,0,0,0,0);
        // skips; config inputs change mid-run
        cfg(3, 4, 2);
        add(0,1,0,0,0, 1,4,0,1,0,0);
        cfg(1, 7, 7);
        add(0,0,0,0,1, 1,3,0,1,0,0);
        add(0,0,1,0,0, 2,4,1,1,2,0);
        add(0,0,0,0,0, 2,4,1,1,2,0);
        add(0,0,1,0,0, 3,4,2,1,2,0);
        add(0,0,1,0,0, 0,0,0,0,3,1);
        add(0,0,0,0,1, 0,0,0,0,0,0);
        // pause in REST; WorkSec=0 lasts one tick
        cfg(1, 0, 5);
        add(0,1,0,0,0, 1,0,0,1,0,0);
        add(0,0,0,0,1, 1,5,0,2,0,0);
        add(0,0,0,1,0, 1,5,0,3,0,0);
        add(0,0,0,0,1, 1,5,0,3,0,0);
        add(0,0,0,0,1, 1,5,0,3,0,0);
        add(0,0,0,0,1, 1,5,0,3,0,0);
        add(0,0,0,0,1, 1,5,0,3,0,0);
        add(0,1,1,0,0, 1,5,0,3,0,0);
        add(0,0,0,1,0, 1,5,0,2,0,0);
        add(0,0,0,0,1, 1,4,0,2,0,0);
        add(0,0,0,1,1, 1,4,0,3,0,0);
        add(0,0,0,1,0, 1,4,0,2,0,0);
        add(0,0,1,0,0, 0,0,0,0,3,1);
        add(0,0,0,0,1, 0,0,0,0,0,0);
        add(0,0,0,1,0, 0,0,0,0,0,0);
        // slot wrap and same-cycle priorities
        cfg(5, 2, 2);
        add(0,1,0,0,0, 1,2,0,1,0,0);
        add(0,0,1,0,0, 2,2,1,1,2,0);
        add(0,0,1,0,0, 3,2,2,1,2,0);
        add(0,0,1,0,0, 4,2,0,1,2,0);
        add(0,0,1,0,1, 5,2,1,1,2,0);
        add(0,0,1,1,0, 5,2,1,3,2,0);
        add(0,0,0,1,0, 5,2,1,1,2,0);
        add(0,0,1,0,0, 0,0,0,0,3,1);
        add(0,0,0,0,1, 0,0,0,0,0,0);
        // reset mid-WORK at Cn=4, then St with Total=0
        cfg(5, 3, 3);
        add(0,1,0,0,0, 1,3,0,1,0,0);
        add(0,0,1,0,0, 2,3,1,1,2,0);
        add(0,0,1,0,0, 3,3,2,1,2,0);
        add(0,0,1,0,0, 4,3,0,1,2,0);
        add(0,0,0,0,1, 4,2,0,1,0,0);
        add(1,1,1,1,1, 0,0,0,0,0,0);
        cfg(0, 3, 3);
        add(0,1,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0,1, 0,0,0,0,0,0);

        foreach (vecs[i]) apply(vecs[i], i);

        // hand sequence: Total=1 W=1 R=0 finishes on the third tick
        @(negedge clk);
        total = CNT_W'(1); work_sec = TI_W'(1); rest_sec = '0;
        st = 1; sk = 0; pa = 0; tick = 0; re = 0;
        @(negedge clk);
        st = 0;
        ticks = 0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick = 1;
            ticks++;
            @(posedge clk);
            #1;
            seen = done;
            @(negedge clk);
            tick = 0;
        end
        chk("run_done_seen", int'(seen), 1);
        chk("run_tick_count", ticks, 3);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
        chk("done_bu_hold", int'(bu), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
